// File: rtl/sram_arbiter.sv
// Serialises loader write strobes and level-style CPU accesses onto the single
// SDRAM byte port. Loader has fixed priority; each requester has one pending slot.
module sram_arbiter #(
  parameter int unsigned AW         = 23,
  parameter int unsigned DW         = 8,
  parameter int unsigned SETTLE_CYC = 2
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_active,
  input  logic          dl_wr,
  input  logic [AW-1:0] dl_addr,
  input  logic [DW-1:0] dl_data,
  output logic          dl_busy,
  output logic          dl_overrun,
  input  logic          cpu_n_cs,
  input  logic          cpu_n_oe,
  input  logic          cpu_n_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_d,
  output logic [DW-1:0] cpu_q,
  output logic          cpu_ready,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_din,
  output logic          mem_we,
  output logic          mem_rd,
  input  logic [DW-1:0] mem_dout,
  input  logic          mem_ready
);

  localparam int unsigned CW = 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          start_c, done_c;

  logic          act_c, act_q, cpu_edge_c;
  logic [AW-1:0] dl_addr_q, cpu_addr_q;
  logic [DW-1:0] dl_data_q, cpu_d_q;
  logic          cpu_wr_q;
  logic          sel_dl_q;

  // A CPU request is a new assertion of chip select with a strobe, outside downloads
  assign act_c      = ~cpu_n_cs & (~cpu_n_oe | ~cpu_n_we);
  assign cpu_edge_c = act_c & ~act_q & ~dl_active & cpu_ready;

  // State register
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; start_c/done_c mark the winner choice and the completion cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    start_c = 1'b0;
    done_c  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((dl_busy | ~cpu_ready) & mem_ready) begin
          state_d = S_ISSUE;
          start_c = 1'b1;
        end
      end
      S_ISSUE: begin
        state_d = S_SETTLE;
        cnt_d   = CW'(SETTLE_CYC - 1);
      end
      S_SETTLE: begin
        if (cnt_q == '0) state_d = S_WAIT;
        else             cnt_d   = cnt_q - CW'(1);
      end
      S_WAIT: begin
        if (mem_ready) begin
          state_d = S_IDLE;
          done_c  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Request slots, command outputs and requester release
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      act_q      <= 1'b0;
      dl_addr_q  <= '0;
      dl_data_q  <= '0;
      dl_busy    <= 1'b0;
      dl_overrun <= 1'b0;
      cpu_addr_q <= '0;
      cpu_d_q    <= '0;
      cpu_wr_q   <= 1'b0;
      cpu_q      <= '0;
      cpu_ready  <= 1'b1;
      sel_dl_q   <= 1'b0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_we     <= 1'b0;
      mem_rd     <= 1'b0;
    end else begin
      act_q  <= act_c;
      mem_we <= 1'b0;
      mem_rd <= 1'b0;

      if (start_c) begin
        sel_dl_q <= dl_busy;
        if (dl_busy) begin
          mem_addr <= dl_addr_q;
          mem_din  <= dl_data_q;
          mem_we   <= 1'b1;
        end else begin
          mem_addr <= cpu_addr_q;
          mem_din  <= cpu_d_q;
          mem_we   <= cpu_wr_q;
          mem_rd   <= ~cpu_wr_q;
        end
      end

      if (done_c & sel_dl_q) dl_busy <= 1'b0;

      // A strobe while the slot is still held (including its completion cycle) is lost
      if (dl_wr) begin
        if (dl_busy) begin
          dl_overrun <= 1'b1;
        end else begin
          dl_addr_q <= dl_addr;
          dl_data_q <= dl_data;
          dl_busy   <= 1'b1;
        end
      end

      if (done_c & ~sel_dl_q) begin
        cpu_ready <= 1'b1;
        if (~cpu_wr_q) cpu_q <= mem_dout;
      end

      if (cpu_edge_c) begin
        cpu_addr_q <= cpu_addr;
        cpu_d_q    <= cpu_d;
        cpu_wr_q   <= ~cpu_n_we;
        cpu_ready  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: expected memory commands and CPU read results
// are queued by the stimulus and consumed by a monitor when the DUT presents them.
module tb_sram_arbiter;

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 8;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic          dl_active, dl_wr;
  logic [AW-1:0] dl_addr;
  logic [DW-1:0] dl_data;
  logic          dl_busy, dl_overrun;
  logic          cpu_n_cs, cpu_n_oe, cpu_n_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_d;
  logic [DW-1:0] cpu_q;
  logic          cpu_ready;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_din;
  logic          mem_we, mem_rd;
  logic [DW-1:0] mem_dout = '0;
  logic          mem_ready;

  always #5 clk_sys = ~clk_sys;

  sram_arbiter #(.AW(AW), .DW(DW), .SETTLE_CYC(2)) dut (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .dl_active (dl_active),
    .dl_wr     (dl_wr),
    .dl_addr   (dl_addr),
    .dl_data   (dl_data),
    .dl_busy   (dl_busy),
    .dl_overrun(dl_overrun),
    .cpu_n_cs  (cpu_n_cs),
    .cpu_n_oe  (cpu_n_oe),
    .cpu_n_we  (cpu_n_we),
    .cpu_addr  (cpu_addr),
    .cpu_d     (cpu_d),
    .cpu_q     (cpu_q),
    .cpu_ready (cpu_ready),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_rd    (mem_rd),
    .mem_dout  (mem_dout),
    .mem_ready (mem_ready)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } cmd_t;

  typedef struct packed {
    logic          rd;
    logic [DW-1:0] q;
  } cpl_t;

  cmd_t cmd_q[$];
  cpl_t cpl_q[$];
  cmd_t exp_cmd;
  cpl_t exp_cpl;
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory model: stays busy slow_n cycles after each command, hold_low forces busy
  int   busy_cnt = 0;
  int   slow_n   = 0;
  logic hold_low = 1'b0;
  assign mem_ready = (busy_cnt == 0) && !hold_low;

  function automatic logic [DW-1:0] rom(input logic [AW-1:0] a);
    case (a)
      23'h004000: return 8'h3C;
      23'h004001: return 8'h5A;
      default:    return 8'h00;
    endcase
  endfunction

  always @(posedge clk_sys) begin
    if (mem_we || mem_rd) busy_cnt <= slow_n;
    else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (mem_rd) mem_dout <= rom(mem_addr);
  end

  // Monitor: every command pops one expectation; every CPU release pops one completion
  logic cpu_ready_prev = 1'b1;
  always @(negedge clk_sys) begin
    if (mem_we || mem_rd) begin
      check("cmd_exclusive", 32'(mem_we & mem_rd), 32'd0);
      if (cmd_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_cmd: got we=%0b rd=%0b addr=0x%0h, expected no command", mem_we, mem_rd, mem_addr);
      end else begin
        exp_cmd = cmd_q.pop_front();
        check("cmd_we",   32'(mem_we),   32'(exp_cmd.we));
        check("cmd_addr", 32'(mem_addr), 32'(exp_cmd.addr));
        if (exp_cmd.we) check("cmd_din", 32'(mem_din), 32'(exp_cmd.data));
      end
    end
    if (cpu_ready && !cpu_ready_prev && !reset) begin
      if (cpl_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_cpu_release: got cpu_ready rise, expected none");
      end else begin
        exp_cpl = cpl_q.pop_front();
        if (exp_cpl.rd) check("cpu_q", 32'(cpu_q), 32'(exp_cpl.q));
      end
    end
    cpu_ready_prev = cpu_ready;
  end

  // Cycles (counted from 1) until the loader slot frees and the CPU is ready
  task automatic track(input int budget, output int dl_c, output int cpu_c);
    dl_c  = -1;
    cpu_c = -1;
    for (int c = 1; c <= budget; c++) begin
      @(negedge clk_sys);
      if (dl_c < 0 && !dl_busy) dl_c = c;
      if (cpu_c < 0 && cpu_ready) cpu_c = c;
      if (dl_c >= 0 && cpu_c >= 0) break;
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_addr"},   32'(mem_addr),   32'd0);
    check({tag, "_mem_din"},    32'(mem_din),    32'd0);
    check({tag, "_mem_we"},     32'(mem_we),     32'd0);
    check({tag, "_mem_rd"},     32'(mem_rd),     32'd0);
    check({tag, "_cpu_q"},      32'(cpu_q),      32'd0);
    check({tag, "_cpu_ready"},  32'(cpu_ready),  32'd1);
    check({tag, "_dl_busy"},    32'(dl_busy),    32'd0);
    check({tag, "_dl_overrun"}, 32'(dl_overrun), 32'd0);
  endtask

  task automatic cpu_idle();
    cpu_n_cs = 1'b1;
    cpu_n_oe = 1'b1;
    cpu_n_we = 1'b1;
  endtask

  int dl_c, cpu_c;

  initial begin
    reset     = 1'b1;
    dl_active = 1'b0;
    dl_wr     = 1'b0;
    dl_addr   = '0;
    dl_data   = '0;
    cpu_addr  = '0;
    cpu_d     = '0;
    cpu_idle();

    repeat (3) @(negedge clk_sys);
    check_reset_values("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);

    // 1: single loader write
    dl_addr = 23'h000100; dl_data = 8'hA5; dl_wr = 1'b1;
    cmd_q.push_back('{we: 1'b1, addr: 23'h000100, data: 8'hA5});
    @(negedge clk_sys);
    dl_wr = 1'b0;
    check("t1_busy_set", 32'(dl_busy), 32'd1);
    track(40, dl_c, cpu_c);
    check("t1_dl_release_cycle", 32'(dl_c), 32'd5);
    @(negedge clk_sys);

    // 2: CPU read
    cpu_n_cs = 1'b0; cpu_n_oe = 1'b0; cpu_addr = 23'h004000;
    cmd_q.push_back('{we: 1'b0, addr: 23'h004000, data: 8'h00});
    cpl_q.push_back('{rd: 1'b1, q: 8'h3C});
    @(negedge clk_sys);
    check("t2_ready_low", 32'(cpu_ready), 32'd0);
    track(40, dl_c, cpu_c);
    check("t2_cpu_release_cycle", 32'(cpu_c), 32'd5);
    check("t2_cpu_q_held", 32'(cpu_q), 32'h3C);
    cpu_idle();
    repeat (2) @(negedge clk_sys);

    // 3: collision, loader first then CPU write (oe and we both low means write)
    dl_addr = 23'h000010; dl_data = 8'h55; dl_wr = 1'b1;
    cpu_n_cs = 1'b0; cpu_n_oe = 1'b0; cpu_n_we = 1'b0; cpu_addr = 23'h000020; cpu_d = 8'hAA;
    cmd_q.push_back('{we: 1'b1, addr: 23'h000010, data: 8'h55});
    cmd_q.push_back('{we: 1'b1, addr: 23'h000020, data: 8'hAA});
    cpl_q.push_back('{rd: 1'b0, q: 8'h00});
    @(negedge clk_sys);
    dl_wr = 1'b0;
    check("t3_dl_busy", 32'(dl_busy), 32'd1);
    check("t3_cpu_pending", 32'(cpu_ready), 32'd0);
    track(60, dl_c, cpu_c);
    check("t3_dl_release_cycle", 32'(dl_c), 32'd5);
    check("t3_cpu_release_cycle", 32'(cpu_c), 32'd10);
    cpu_idle();
    repeat (2) @(negedge clk_sys);

    // CPU edges are ignored while a download is active
    dl_active = 1'b1;
    cpu_n_cs = 1'b0; cpu_n_oe = 1'b0; cpu_addr = 23'h004000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_sys);
      check("gate_cpu_ready", 32'(cpu_ready), 32'd1);
    end
    cpu_idle();
    @(negedge clk_sys);
    dl_active = 1'b0;
    @(negedge clk_sys);

    // 4: overrun, second strobe two cycles after the first is dropped
    dl_addr = 23'h000200; dl_data = 8'h11; dl_wr = 1'b1;
    cmd_q.push_back('{we: 1'b1, addr: 23'h000200, data: 8'h11});
    @(negedge clk_sys);
    dl_wr = 1'b0;
    check("t4_no_overrun_yet", 32'(dl_overrun), 32'd0);
    @(negedge clk_sys);
    dl_addr = 23'h000300; dl_data = 8'h22; dl_wr = 1'b1;
    @(negedge clk_sys);
    dl_wr = 1'b0;
    check("t4_overrun_set", 32'(dl_overrun), 32'd1);
    track(40, dl_c, cpu_c);
    check("t4_dl_release_cycle", 32'(dl_c), 32'd3);
    repeat (4) @(negedge clk_sys);
    check("t4_overrun_sticky", 32'(dl_overrun), 32'd1);

    // 5: slow memory holds mem_ready low 10 cycles after the read command
    slow_n = 10;
    cpu_n_cs = 1'b0; cpu_n_oe = 1'b0; cpu_addr = 23'h004001;
    cmd_q.push_back('{we: 1'b0, addr: 23'h004001, data: 8'h00});
    cpl_q.push_back('{rd: 1'b1, q: 8'h5A});
    @(negedge clk_sys);
    check("t5_ready_low", 32'(cpu_ready), 32'd0);
    track(60, dl_c, cpu_c);
    check("t5_cpu_release_cycle", 32'(cpu_c), 32'd13);
    cpu_idle();
    slow_n = 0;
    repeat (2) @(negedge clk_sys);

    // 6: reset during SETTLE, then a held-off memory after release
    dl_addr = 23'h000400; dl_data = 8'h77; dl_wr = 1'b1;
    cmd_q.push_back('{we: 1'b1, addr: 23'h000400, data: 8'h77});
    @(negedge clk_sys);
    dl_wr = 1'b0;
    repeat (2) @(negedge clk_sys);
    reset = 1'b1;
    @(negedge clk_sys);
    check_reset_values("t6");
    hold_low = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    dl_addr = 23'h000500; dl_data = 8'h88; dl_wr = 1'b1;
    cmd_q.push_back('{we: 1'b1, addr: 23'h000500, data: 8'h88});
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_sys);
      dl_wr = 1'b0;
      check("t6_no_cmd_while_busy", 32'(mem_we | mem_rd), 32'd0);
      check("t6_dl_held", 32'(dl_busy), 32'd1);
    end
    hold_low = 1'b0;
    track(40, dl_c, cpu_c);
    check("t6_dl_release_cycle", 32'(dl_c), 32'd5);

    repeat (4) @(negedge clk_sys);
    check("cmd_queue_drained", 32'(cmd_q.size()), 32'd0);
    check("cpl_queue_drained", 32'(cpl_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
